// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the reset instruction and the decode field widths.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // addi x0, x0, 0 -- harmless no-op held in the instruction register
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int OP_W       = 7;
  localparam int FUNCT3_W   = 3;
  localparam int FUNCT7_5_W = 1;

  // True when an address lands on a 32-bit word boundary
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC arithmetic for the fetch unit: sequential or branch target select
// and a word-alignment check on the selected target.
module pc_next
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pc_src,
  input  logic [31:0] imm_ext,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  // Select fall-through or branch target; both wrap modulo 2^32
  always_comb begin
    pc_plus4   = pc + 32'd4;
    next_pc    = pc_src ? (pc + imm_ext) : (pc + 32'd4);
    misaligned = !is_word_aligned(next_pc);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests a word from instruction memory, holds it
// for decode until the datapath retires it, then advances the PC.
// Build option: define FETCH_MISALIGN_TRAP_EN to halt with fetch_err on a
// misaligned next PC; otherwise the next PC is silently forced word-aligned.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          WAIT_MAX = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [31:0]           imem_addr,
  input  logic                  imem_valid,
  input  logic [31:0]           imem_rdata,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [OP_W-1:0]       op,
  output logic [FUNCT3_W-1:0]   funct3,
  output logic [FUNCT7_5_W-1:0] funct7_5,
  output logic [31:0]           pc,
  output logic [31:0]           pc_plus4,
  input  logic                  exec_ack,
  input  logic                  PCSrc,
  input  logic [31:0]           ImmExt,
  output logic [31:0]           instret,
  output logic                  fetch_err
);

  localparam logic [31:0] WAIT_LIMIT = 32'(WAIT_MAX);

  fetch_state_e state_r;
  fetch_state_e state_s;
  logic [31:0]  pc_r;
  logic [31:0]  instr_r;
  logic [31:0]  instret_r;
  logic [31:0]  wait_cnt_r;
  logic         fetch_err_r;

  logic [31:0]  pc_plus4_s;
  logic [31:0]  next_pc_s;
  logic         misaligned_s;
  logic [31:0]  pc_load_val_s;
  logic         capture_s;
  logic         retire_s;
  logic         pc_load_s;
  logic         err_set_s;
  logic         cnt_clr_s;
  logic         cnt_inc_s;

  pc_next u_pc_next (
    .pc         (pc_r),
    .pc_src     (PCSrc),
    .imm_ext    (ImmExt),
    .pc_plus4   (pc_plus4_s),
    .next_pc    (next_pc_s),
    .misaligned (misaligned_s)
  );

  // Value written into the PC on retirement (aligned down unless trapping)
  always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
    pc_load_val_s = next_pc_s;
`else
    pc_load_val_s = {next_pc_s[31:2], 2'b00};
`endif
  end

  // Next-state and datapath strobes for the fetch sequencer
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    retire_s  = 1'b0;
    pc_load_s = 1'b0;
    err_set_s = 1'b0;
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    case (state_r)
      ST_REQ: begin
        cnt_clr_s = 1'b1;
        state_s   = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_valid) begin
          capture_s = 1'b1;
          state_s   = ST_ISSUE;
        end else if ((wait_cnt_r + 32'd1) == WAIT_LIMIT) begin
          err_set_s = 1'b1;
          state_s   = ST_HALT;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (exec_ack) begin
          retire_s = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (misaligned_s) begin
            err_set_s = 1'b1;
            state_s   = ST_HALT;
          end else begin
            pc_load_s = 1'b1;
            state_s   = ST_REQ;
          end
`else
          pc_load_s = 1'b1;
          state_s   = ST_REQ;
`endif
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_HALT: begin
        state_s = ST_HALT;
      end
      default: begin
        state_s = ST_REQ;
      end
    endcase
  end

  // State, PC, instruction register, counters and sticky fault flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_REQ;
      pc_r        <= RESET_PC;
      instr_r     <= NOP_INSTR;
      instret_r   <= 32'd0;
      wait_cnt_r  <= 32'd0;
      fetch_err_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (capture_s) instr_r <= imem_rdata;
      if (pc_load_s) pc_r <= pc_load_val_s;
      if (retire_s) instret_r <= instret_r + 32'd1;
      if (cnt_clr_s) begin
        wait_cnt_r <= 32'd0;
      end else if (cnt_inc_s) begin
        wait_cnt_r <= wait_cnt_r + 32'd1;
      end
      if (err_set_s) fetch_err_r <= 1'b1;
    end
  end

  // Outputs decoded from registered state; request is quiet while in reset
  always_comb begin
    imem_req    = !reset && ((state_r == ST_REQ) || (state_r == ST_WAIT));
    instr_valid = !reset && (state_r == ST_ISSUE);
    imem_addr   = pc_r;
    pc          = pc_r;
    pc_plus4    = pc_plus4_s;
    instr       = instr_r;
    op          = instr_r[6:0];
    funct3      = instr_r[14:12];
    funct7_5    = instr_r[30];
    instret     = instret_r;
    fetch_err   = fetch_err_r;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (WAIT_MAX reduced to 3).
// Expected results for the misalign case follow FETCH_MISALIGN_TRAP_EN.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [0:0]  funct7_5;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exec_ack;
  logic        PCSrc;
  logic [31:0] ImmExt;
  logic [31:0] instret;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit #(.RESET_PC(32'h0000_0000), .WAIT_MAX(3)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .op(op), .funct3(funct3), .funct7_5(funct7_5), .pc(pc),
    .pc_plus4(pc_plus4), .exec_ack(exec_ack), .PCSrc(PCSrc), .ImmExt(ImmExt),
    .instret(instret), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step();
    step();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_ivalid got=%b exp=0", instr_valid); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc); end
    total++; if (instr !== NOP) begin bad++; $display("FAIL rst_instr got=%h exp=%h", instr, NOP); end
    total++; if (instret !== 32'h0) begin bad++; $display("FAIL rst_instret got=%h exp=0", instret); end
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", fetch_err); end
  endtask

  task automatic test_fetch;
    reset = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL fetch_req_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL fetch_addr got=%h exp=0", imem_addr); end
    step();
    imem_valid = 1'b1; imem_rdata = 32'h0000_0033;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL fetch_req_wait got=%b exp=1", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL fetch_ivalid_wait got=%b exp=0", instr_valid); end
    step();
    imem_valid = 1'b0;
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL fetch_ivalid got=%b exp=1", instr_valid); end
    total++; if (instr !== 32'h0000_0033) begin bad++; $display("FAIL fetch_instr got=%h exp=00000033", instr); end
    total++; if (op !== 7'b0110011) begin bad++; $display("FAIL fetch_op got=%b exp=0110011", op); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL fetch_pc got=%h exp=0", pc); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL fetch_req_issue got=%b exp=0", imem_req); end
    total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL fetch_pcp4 got=%h exp=4", pc_plus4); end
    // stray response and branch inputs while issuing without ack
    imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF; PCSrc = 1'b1; ImmExt = 32'h0000_0100;
    step();
    imem_valid = 1'b0; PCSrc = 1'b0; ImmExt = 32'h0;
    total++; if (instr !== 32'h0000_0033) begin bad++; $display("FAIL hold_instr got=%h exp=00000033", instr); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL hold_pc got=%h exp=0", pc); end
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL hold_ivalid got=%b exp=1", instr_valid); end
  endtask

  task automatic test_retire;
    exec_ack = 1'b1; PCSrc = 1'b0;
    step();
    // ack left high into REQ must be ignored
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL ret_pc got=%h exp=4", pc); end
    total++; if (instret !== 32'd1) begin bad++; $display("FAIL ret_instret got=%0d exp=1", instret); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL ret_req got=%b exp=1", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL ret_ivalid got=%b exp=0", instr_valid); end
    step();
    exec_ack = 1'b0;
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL ack_ign_pc got=%h exp=4", pc); end
    total++; if (instret !== 32'd1) begin bad++; $display("FAIL ack_ign_instret got=%0d exp=1", instret); end
    imem_valid = 1'b1; imem_rdata = 32'h4000_50B3;
    step();
    imem_valid = 1'b0;
    total++; if (instr !== 32'h4000_50B3) begin bad++; $display("FAIL ret_instr got=%h exp=400050b3", instr); end
    total++; if (funct3 !== 3'd5) begin bad++; $display("FAIL ret_funct3 got=%0d exp=5", funct3); end
    total++; if (funct7_5 !== 1'b1) begin bad++; $display("FAIL ret_funct7_5 got=%b exp=1", funct7_5); end
    total++; if (pc_plus4 !== 32'h8) begin bad++; $display("FAIL ret_pcp4 got=%h exp=8", pc_plus4); end
  endtask

  task automatic test_branch;
    exec_ack = 1'b1; PCSrc = 1'b0;
    step();
    exec_ack = 1'b0;
    total++; if (pc !== 32'h8) begin bad++; $display("FAIL br_pc8 got=%h exp=8", pc); end
    step();
    imem_valid = 1'b1; imem_rdata = 32'h0000_0063;
    step();
    imem_valid = 1'b0;
    exec_ack = 1'b1; PCSrc = 1'b1; ImmExt = 32'hFFFF_FFF8;
    step();
    exec_ack = 1'b0; PCSrc = 1'b0; ImmExt = 32'h0;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL br_pc got=%h exp=0", pc); end
    total++; if (instret !== 32'd3) begin bad++; $display("FAIL br_instret got=%0d exp=3", instret); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL br_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_misalign;
    step();
    imem_valid = 1'b1; imem_rdata = 32'h0000_0063;
    step();
    imem_valid = 1'b0;
    exec_ack = 1'b1; PCSrc = 1'b1; ImmExt = 32'h0000_0006;
    step();
    exec_ack = 1'b0; PCSrc = 1'b0; ImmExt = 32'h0;
    total++; if (instret !== 32'd4) begin bad++; $display("FAIL mis_instret got=%0d exp=4", instret); end
`ifdef FETCH_MISALIGN_TRAP_EN
    total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL mis_err got=%b exp=1", fetch_err); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL mis_pc got=%h exp=0", pc); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mis_req got=%b exp=0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mis_ivalid got=%b exp=0", instr_valid); end
`else
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL mis_err got=%b exp=0", fetch_err); end
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL mis_pc got=%h exp=4", pc); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL mis_req got=%b exp=1", imem_req); end
`endif
  endtask

  task automatic test_timeout;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL to_err_clr got=%b exp=0", fetch_err); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL to_req0 got=%b exp=1", imem_req); end
    step();
    step();
    step();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL to_req_w3 got=%b exp=1", imem_req); end
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL to_err_w3 got=%b exp=0", fetch_err); end
    step();
    total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", fetch_err); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL to_req got=%b exp=0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL to_ivalid got=%b exp=0", instr_valid); end
    imem_valid = 1'b1; imem_rdata = 32'h0000_0033; exec_ack = 1'b1;
    step();
    step();
    imem_valid = 1'b0; exec_ack = 1'b0;
    total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL halt_err got=%b exp=1", fetch_err); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_req got=%b exp=0", imem_req); end
    total++; if (instr !== NOP) begin bad++; $display("FAIL halt_instr got=%h exp=%h", instr, NOP); end
    total++; if (instret !== 32'd0) begin bad++; $display("FAIL halt_instret got=%0d exp=0", instret); end
  endtask

  task automatic test_reset_mid_wait;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rmw_req_rst got=%b exp=0", imem_req); end
    step();
    reset = 1'b0; imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rmw_req got=%b exp=1", imem_req); end
    step();
    imem_valid = 1'b0;
    total++; if (instr !== NOP) begin bad++; $display("FAIL rmw_instr got=%h exp=%h", instr, NOP); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL rmw_pc got=%h exp=0", pc); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rmw_ivalid got=%b exp=0", instr_valid); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rmw_req_wait got=%b exp=1", imem_req); end
    imem_valid = 1'b1; imem_rdata = 32'h0000_0033;
    step();
    imem_valid = 1'b0;
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL rmw_restart got=%b exp=1", instr_valid); end
    total++; if (instr !== 32'h0000_0033) begin bad++; $display("FAIL rmw_instr2 got=%h exp=00000033", instr); end
  endtask

  initial begin
    reset = 1'b1; imem_valid = 1'b0; imem_rdata = 32'h0;
    exec_ack = 1'b0; PCSrc = 1'b0; ImmExt = 32'h0;
    test_reset();
    test_fetch();
    test_retire();
    test_branch();
    test_misalign();
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
